// File: rtl/wb_regfile.sv
// MIPS write-back stage: selects the write-back value and commits it to a 32-entry register file.
// Optional WB_BYPASS_EN macro enables same-cycle write-through on both read ports.
module wb_regfile #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  RegWrite,
    input  logic [1:0]            MemtoReg,
    input  logic [ADDR_WIDTH-1:0] Write_register,
    input  logic [WIDTH-1:0]      ALU_out,
    input  logic [WIDTH-1:0]      Read_data,
    input  logic [WIDTH-1:0]      PC_plus_4,
    input  logic [ADDR_WIDTH-1:0] Read_register1,
    input  logic [ADDR_WIDTH-1:0] Read_register2,
    output logic [WIDTH-1:0]      Read_data1,
    output logic [WIDTH-1:0]      Read_data2,
    output logic [WIDTH-1:0]      Write_data
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [WIDTH-1:0] regs [DEPTH];
    logic             wr_en;

    // Write-back source mux; 2'b11 aliases the ALU result
    always_comb begin
        Write_data = ALU_out;
        case (MemtoReg)
            2'b01:   Write_data = Read_data;
            2'b10:   Write_data = PC_plus_4;
            default: Write_data = ALU_out;
        endcase
    end

    assign wr_en = reset && RegWrite && (Write_register != '0);

    // Entry 0 is cleared by reset and never written, so it stays zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[ADDR_WIDTH'(i)] <= '0;
            end
        end else if (wr_en) begin
            regs[Write_register] <= Write_data;
        end
    end

    always_comb begin
        Read_data1 = (Read_register1 == '0) ? '0 : regs[Read_register1];
        Read_data2 = (Read_register2 == '0) ? '0 : regs[Read_register2];
`ifdef WB_BYPASS_EN
        if (wr_en && (Read_register1 == Write_register)) begin
            Read_data1 = Write_data;
        end
        if (wr_en && (Read_register2 == Write_register)) begin
            Read_data2 = Write_data;
        end
`endif
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: stimulus pushes expected port values, a negedge monitor checks them.
module tb_wb_regfile;

    logic        clk;
    logic        reset;
    logic        RegWrite;
    logic [1:0]  MemtoReg;
    logic [4:0]  Write_register;
    logic [31:0] ALU_out;
    logic [31:0] Read_data;
    logic [31:0] PC_plus_4;
    logic [4:0]  Read_register1;
    logic [4:0]  Read_register2;
    logic [31:0] Read_data1;
    logic [31:0] Read_data2;
    logic [31:0] Write_data;

    wb_regfile #(.WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk(clk),
        .reset(reset),
        .RegWrite(RegWrite),
        .MemtoReg(MemtoReg),
        .Write_register(Write_register),
        .ALU_out(ALU_out),
        .Read_data(Read_data),
        .PC_plus_4(PC_plus_4),
        .Read_register1(Read_register1),
        .Read_register2(Read_register2),
        .Read_data1(Read_data1),
        .Read_data2(Read_data2),
        .Write_data(Write_data)
    );

    typedef struct {
        string       tag;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] wd;
    } exp_t;

    exp_t        q[$];
    logic [31:0] model [32];
    int          checks   = 0;
    int          failures = 0;
    logic        stim_done = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: architectural view of the register file
    function automatic logic [31:0] wd_ref();
        if (MemtoReg == 2'd1) return Read_data;
        if (MemtoReg == 2'd2) return PC_plus_4;
        return ALU_out;
    endfunction

    function automatic logic commit_now();
        return reset && RegWrite && (Write_register != 5'd0);
    endfunction

    function automatic logic [31:0] rd_ref(input logic [4:0] a);
        if (!reset || a == 5'd0) return 32'h0;
`ifdef WB_BYPASS_EN
        if (commit_now() && a == Write_register) return wd_ref();
`endif
        return model[a];
    endfunction

    function automatic void push_exp(input string tag);
        exp_t e;
        e.tag = tag;
        e.rd1 = rd_ref(Read_register1);
        e.rd2 = rd_ref(Read_register2);
        e.wd  = wd_ref();
        q.push_back(e);
    endfunction

    function automatic void clear_model();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endfunction

    // Called at posedge+1 with inputs already driven
    task automatic cycle(input string tag);
        logic        c;
        logic [4:0]  a;
        logic [31:0] v;
        push_exp(tag);
        c = commit_now();
        a = Write_register;
        v = wd_ref();
        @(posedge clk);
        if (c && reset) model[a] = v;
        #1;
    endtask

    task automatic drive(input logic we, input logic [1:0] sel, input logic [4:0] wr,
                         input logic [31:0] alu, input logic [31:0] ld, input logic [31:0] pc,
                         input logic [4:0] r1, input logic [4:0] r2);
        RegWrite = we; MemtoReg = sel; Write_register = wr;
        ALU_out = alu; Read_data = ld; PC_plus_4 = pc;
        Read_register1 = r1; Read_register2 = r2;
    endtask

    // Monitor: combinational outputs are settled by the falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (Read_data1 !== e.rd1) begin
                    failures++;
                    $display("FAIL %s rd1 got %h want %h", e.tag, Read_data1, e.rd1);
                end
                checks++;
                if (Read_data2 !== e.rd2) begin
                    failures++;
                    $display("FAIL %s rd2 got %h want %h", e.tag, Read_data2, e.rd2);
                end
                checks++;
                if (Write_data !== e.wd) begin
                    failures++;
                    $display("FAIL %s wd got %h want %h", e.tag, Write_data, e.wd);
                end
            end
        end
    end

    initial begin
        reset = 1'b0;
        clear_model();
        drive(1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
        @(posedge clk); #1;

        // Reads while reset is held
        drive(1'b1, 2'd0, 5'd3, 32'h1111_2222, 32'h0, 32'h0, 5'd3, 5'd4);
        cycle("in_reset");
        reset = 1'b1;
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'(i), 5'(31 - i));
            cycle("post_reset");
        end

        // Select and commit
        drive(1'b1, 2'd0, 5'd5,  32'h1234_5678, 32'hDEAD_BEEF, 32'h0040_0010, 5'd5, 5'd6);
        cycle("sel_alu");
        drive(1'b1, 2'd1, 5'd6,  32'h1234_5678, 32'hDEAD_BEEF, 32'h0040_0010, 5'd5, 5'd6);
        cycle("sel_load");
        drive(1'b1, 2'd2, 5'd31, 32'h1234_5678, 32'hDEAD_BEEF, 32'h0040_0010, 5'd6, 5'd31);
        cycle("sel_pc4");
        drive(1'b0, 2'd3, 5'd0,  32'h1234_5678, 32'hDEAD_BEEF, 32'h0040_0010, 5'd5, 5'd31);
        cycle("sel_alias");
        if (model[5] != 32'h1234_5678 || model[6] != 32'hDEAD_BEEF || model[31] != 32'h0040_0010)
            $display("note: reference model diverged from directed values");

        // $zero protection
        drive(1'b1, 2'd0, 5'd0, 32'hFFFF_FFFF, 32'h0, 32'h0, 5'd0, 5'd0);
        cycle("zero_wr");
        cycle("zero_after");

        // Write disabled
        drive(1'b0, 2'd0, 5'd7, 32'hA5A5_A5A5, 32'h0, 32'h0, 5'd7, 5'd7);
        cycle("wr_dis");
        cycle("wr_dis_after");

        // Same-cycle read/write of reg 9
        drive(1'b1, 2'd0, 5'd9, 32'h1, 32'h0, 32'h0, 5'd9, 5'd9);
        cycle("rw_seed");
        drive(1'b1, 2'd0, 5'd9, 32'h2, 32'h0, 32'h0, 5'd9, 5'd9);
        cycle("rw_same");
        drive(1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd9, 5'd9);
        cycle("rw_after");

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            logic [4:0] wr;
            wr = 5'($urandom_range(0, 31));
            drive(1'($urandom), 2'($urandom_range(0, 3)), wr, $urandom, $urandom, $urandom,
                  ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31)));
            cycle("rand");
        end

        // Fill all registers with distinct values
        for (int i = 1; i < 32; i++) begin
            drive(1'b1, 2'd0, 5'(i), (32'(i) * 32'h0101_0101) ^ 32'h8000_0000, 32'h0, 32'h0,
                  5'(i), 5'(32 - i));
            cycle("fill");
        end

        // Reset pulse between edges: reads must drop to zero immediately
        drive(1'b0, 2'd0, 5'd0, 32'h5555_AAAA, 32'h0, 32'h0, 5'd17, 5'd31);
        #2 reset = 1'b0;
        clear_model();
        push_exp("pulse");
        #3 reset = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'($urandom_range(1, 31)),
                  5'($urandom_range(1, 31)));
            cycle("after_pulse");
        end

        // Write on an edge while reset is low is lost
        reset = 1'b0;
        clear_model();
        drive(1'b1, 2'd0, 5'd12, 32'hCAFE_F00D, 32'h0, 32'h0, 5'd12, 5'd12);
        cycle("wr_in_reset");
        reset = 1'b1;
        drive(1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd12, 5'd12);
        cycle("wr_in_reset_after");
        drive(1'b1, 2'd1, 5'd12, 32'h0, 32'h7777_0001, 32'h0, 5'd1, 5'd12);
        cycle("first_wr");
        drive(1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd12, 5'd0);
        cycle("first_wr_after");

        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got %0d pending want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
